// File: rtl/mean_filter_pkg.sv
// Shared definitions for the time-shared sliding-window mean engine:
// FSM encoding plus width helpers used to size channel indices and running sums.
package mean_filter_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_READ   = 2'd1;
    localparam logic [ST_W-1:0] ST_UPDATE = 2'd2;
    localparam logic [ST_W-1:0] ST_OUT    = 2'd3;

    // Ceiling log2 with a floor of 1 so a channel index is never zero bits wide.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int sum_width(input int dw, input int win_log2);
        return dw + win_log2;
    endfunction

endpackage

// File: rtl/mean_filter_arb_window_ram.sv
// Window sample store shared by all channels: one write port, one registered read port.
// Address is {channel, slot}; contents are deliberately left uninitialised.
module window_ram #(
    parameter int DW    = 24,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mean_filter_arb.sv
// CH-channel sliding-window mean: a round-robin arbiter feeds one running-sum datapath
// that reads the evicted sample, updates the channel sum, writes back and reports sum/N.
module mean_filter_arb
    import mean_filter_pkg::*;
#(
    parameter int CH       = 4,
    parameter int DW       = 24,
    parameter int WIN_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [CH-1:0]        in_valid,
    input  logic [CH*DW-1:0]     in_data,
    output logic [CH-1:0]        in_ready,
    output logic                 out_valid,
    output logic [clog2(CH)-1:0] out_ch,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready
);

    localparam int CH_W  = clog2(CH);
    localparam int SUM_W = sum_width(DW, WIN_LOG2);
    localparam int AW    = CH_W + WIN_LOG2;
    localparam logic [WIN_LOG2:0] FILL_FULL = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CH - 1);

    logic [ST_W-1:0]     state_q, state_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     g_q, g_d;
    logic [DW-1:0]       new_q, new_d;
    logic [SUM_W-1:0]    sum_q  [CH];
    logic [SUM_W-1:0]    sum_d  [CH];
    logic [WIN_LOG2-1:0] wptr_q [CH];
    logic [WIN_LOG2-1:0] wptr_d [CH];
    logic [WIN_LOG2:0]   fill_q [CH];
    logic [WIN_LOG2:0]   fill_d [CH];
    logic [DW-1:0]       out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic [DW-1:0]       in_word [CH];
    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic                fire;
    logic [DW-1:0]       old_val;
    logic [SUM_W-1:0]    sum_upd;
    logic                ram_we;
    logic [DW-1:0]       ram_rdata;

    for (genvar c = 0; c < CH; c++) begin : g_unpack
        assign in_word[c] = in_data[c*DW +: DW];
    end

    // Scan from the round-robin pointer, wrapping, and take the first requester.
    always_comb begin : arb_search
        logic [CH_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < CH; i++) begin
            cand = {1'b0, rr_q} + (CH_W + 1)'(i);
            if (cand >= (CH_W + 1)'(CH)) cand = cand - (CH_W + 1)'(CH);
            if (!grant_found && in_valid[cand[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CH_W-1:0];
            end
        end
    end

    assign fire = (state_q == ST_IDLE) && grant_found && !clr && !rst;

    always_comb begin
        in_ready = '0;
        if (fire) in_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        g_d        = g_q;
        new_d      = new_q;
        sum_d      = sum_q;
        wptr_d     = wptr_q;
        fill_d     = fill_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        old_val    = '0;
        sum_upd    = sum_q[g_q];
        ram_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    g_d     = grant_idx;
                    new_d   = in_word[grant_idx];
                    rr_d    = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_UPDATE;
            ST_UPDATE: begin
                // Until the window has filled once, the evicted slot counts as zero.
                old_val = (fill_q[g_q] == FILL_FULL) ? ram_rdata : '0;
                sum_upd = sum_q[g_q] + SUM_W'(new_q) - SUM_W'(old_val);
                sum_d[g_q]  = sum_upd;
                wptr_d[g_q] = wptr_q[g_q] + 1'b1;
                if (fill_q[g_q] != FILL_FULL) fill_d[g_q] = fill_q[g_q] + 1'b1;
                out_data_d = sum_upd[SUM_W-1:WIN_LOG2];
                out_ch_d   = g_q;
                ram_we     = 1'b1;
                state_d    = ST_OUT;
            end
            ST_OUT: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (clr) begin
            state_d = ST_IDLE;
            ram_we  = 1'b0;
            for (int c = 0; c < CH; c++) begin
                sum_d[c]  = '0;
                wptr_d[c] = '0;
                fill_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            g_q        <= '0;
            new_q      <= '0;
            sum_q      <= '{default: '0};
            wptr_q     <= '{default: '0};
            fill_q     <= '{default: '0};
            out_data_q <= '0;
            out_ch_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            g_q        <= g_d;
            new_q      <= new_d;
            sum_q      <= sum_d;
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
        end
    end

    window_ram #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (CH << WIN_LOG2)
    ) u_window_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({g_q, wptr_q[g_q]}),
        .wdata (new_q),
        .re    (fire),
        .raddr ({grant_idx, wptr_q[grant_idx]}),
        .rdata (ram_rdata)
    );

    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mean_filter_arb.sv
// Scoreboard bench for mean_filter_arb: accepted samples feed a per-channel window model
// whose expected means are queued and matched against each result the DUT hands over.
module tb_mean_filter_arb;

    localparam int CH       = 4;
    localparam int DW       = 24;
    localparam int WIN_LOG2 = 6;
    localparam int N        = 1 << WIN_LOG2;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic [CH-1:0]     in_valid;
    logic [CH*DW-1:0]  in_data;
    logic [CH-1:0]     in_ready;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_data;
    logic              out_ready;

    always #5 clk = ~clk;

    mean_filter_arb #(.CH(CH), .DW(DW), .WIN_LOG2(WIN_LOG2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    typedef struct {
        int     ch;
        longint data;
        int     accCyc;
    } exp_t;

    exp_t   sbQueue[$];
    longint win [CH][N];
    int     winCnt [CH];
    int     nChecks = 0;
    int     nFails  = 0;
    int     cyc     = 0;
    int     accCount = 0;
    int     lastGrant = CH - 1;
    int     lastAccCyc = -1;
    logic   prevValid = 1'b0;
    logic   arbOrder = 1'b0;
    logic   arbSpace = 1'b0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: mean of the last N accepted samples of a channel, zero-filled at start.
    function automatic longint modelMean(input int ch);
        longint s = 0;
        for (int i = 0; i < N; i++) s += win[ch][i];
        return s >> WIN_LOG2;
    endfunction

    // Single monitor: model reset, output scoreboard, then accept capture.
    always @(negedge clk) begin
        int g;
        exp_t e;
        if (rst || clr) begin
            sbQueue.delete();
            for (int c = 0; c < CH; c++) begin
                winCnt[c] = 0;
                for (int i = 0; i < N; i++) win[c][i] = 0;
            end
            if (rst) begin
                lastGrant  = CH - 1;
                lastAccCyc = -1;
            end
        end

        if (out_valid && !prevValid && sbQueue.size() != 0)
            checkOutput("latency", 64'(cyc - sbQueue[0].accCyc), 64'd3);
        if (out_valid && out_ready && !rst && !clr) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("out_ch", 64'(out_ch), 64'(e.ch));
                checkOutput("out_data", 64'(out_data), 64'(e.data));
            end
        end
        prevValid = out_valid;

        if (in_ready != '0)
            checkOutput("in_ready_onehot", 64'($onehot(in_ready)), 64'd1);

        g = -1;
        if (!rst && !clr)
            for (int c = 0; c < CH; c++)
                if (in_valid[c] && in_ready[c]) g = c;
        if (g >= 0) begin
            win[g][winCnt[g] % N] = longint'(in_data[g*DW +: DW]);
            winCnt[g]++;
            e.ch = g;
            e.data = modelMean(g);
            e.accCyc = cyc;
            sbQueue.push_back(e);
            if (arbOrder) checkOutput("grant_order", 64'(g), 64'((lastGrant + 1) % CH));
            if (arbSpace && lastAccCyc >= 0) checkOutput("grant_spacing", 64'(cyc - lastAccCyc), 64'd4);
            lastGrant  = g;
            lastAccCyc = cyc;
            accCount++;
        end
    end

    // Offer one sample on one channel and return just after the edge that accepts it.
    task automatic applyStimulus(input int ch, input logic [DW-1:0] val);
        int waited = 0;
        in_valid[ch] = 1'b1;
        in_data[ch*DW +: DW] = val;
        @(negedge clk);
        while (!in_ready[ch] && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready[ch]) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid[ch] = 1'b0;
    endtask

    task automatic waitDrain();
        int g = 0;
        while ((sbQueue.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        checkOutput("drain_pending", 64'(sbQueue.size()), 64'd0);
    endtask

    task automatic waitAccepts(input int target);
        int g = 0;
        while (accCount < target && g < 400) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (accCount < target) checkOutput("accept_count_timeout", 64'(accCount), 64'(target));
    endtask

    task automatic waitOutValid(input string name);
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 50) begin
            g++;
            @(negedge clk);
        end
        if (!out_valid) checkOutput(name, 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] holdData;
        logic [1:0]    holdCh;
        rst = 1'b1;
        clr = 1'b0;
        in_valid = '1;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_ch", 64'(out_ch), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = '0;

        $display("[TB] warm-up on ch0");
        for (int k = 0; k < 70; k++) applyStimulus(0, 24'd100);
        waitDrain();

        $display("[TB] ramp on ch1");
        for (int k = 0; k < 110; k++) applyStimulus(1, DW'(k % 101));
        waitDrain();

        $display("[TB] arbitration, all channels requesting");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = DW'(10 * (c + 1));
        arbOrder = 1'b1;
        arbSpace = 1'b1;
        in_valid = '1;
        waitAccepts(accCount + 16);

        $display("[TB] backpressure");
        arbSpace = 1'b0;
        out_ready = 1'b0;
        waitOutValid("bp_out_valid_timeout");
        holdData = out_data;
        holdCh = out_ch;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_data_stable", 64'(out_data), 64'(holdData));
            checkOutput("bp_ch_stable", 64'(out_ch), 64'(holdCh));
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        waitAccepts(accCount + 8);
        in_valid = '0;
        arbOrder = 1'b0;
        waitDrain();

        $display("[TB] reset in UPDATE, clear in OUT");
        applyStimulus(0, 24'd5);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid[0] = 1'b1;
        in_data[0 +: DW] = 24'd7;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_idle_grant", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        out_ready = 1'b0;
        waitOutValid("clr_out_valid_timeout");
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        out_ready = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0 +: DW] = 24'd64;
        @(negedge clk);
        checkOutput("clr_out_valid", 64'(out_valid), 64'd0);
        checkOutput("clr_idle_grant", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        waitDrain();

        $display("[TB] full-scale on ch2");
        for (int k = 0; k < 80; k++) applyStimulus(2, 24'hFFFFFF);
        waitDrain();

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            in_valid = CH'($urandom);
            for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = DW'($urandom);
            out_ready = ($urandom_range(3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        out_ready = 1'b1;
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
